// File: rtl/zap_cp15_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zap_cp15_responder_pkg
// Purpose : Shared definitions for the CP15 responder: CRn numbers, FSM
//           state encoding, MRC/MCR match pattern, CPU mode codes and the
//           architectural-to-physical register translation.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package zap_cp15_responder_pkg;

  // CP15 register numbers (CRn field).
  localparam logic [3:0] CP15_ID   = 4'd0;
  localparam logic [3:0] CP15_CTRL = 4'd1;
  localparam logic [3:0] CP15_TTB  = 4'd2;
  localparam logic [3:0] CP15_DAC  = 4'd3;
  localparam logic [3:0] CP15_FSR  = 4'd5;
  localparam logic [3:0] CP15_FAR  = 4'd6;

  // word[27:24] pattern shared by MRC/MCR (and CDP); word[4] separates them.
  localparam logic [3:0] MRC_MCR_MATCH = 4'b1110;

  // CPSR mode encodings.
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // Physical register file layout: 0..15 user bank, then banked copies.
  localparam int PHY_IDX_W   = 6;
  localparam int PHY_FIQ_R8  = 16;  // FIQ R8..R14 -> 16..22
  localparam int PHY_IRQ_R13 = 23;  // IRQ R13/R14 -> 23/24
  localparam int PHY_SVC_R13 = 25;  // SVC R13/R14 -> 25/26
  localparam int PHY_ABT_R13 = 27;  // ABT R13/R14 -> 27/28
  localparam int PHY_UND_R13 = 29;  // UND R13/R14 -> 29/30

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic is_mrc_mcr(input logic [31:0] word);
    return (word[27:24] == MRC_MCR_MATCH) && word[4];
  endfunction

  // Map an architectural register number to its physical slot for the mode.
  function automatic logic [PHY_IDX_W-1:0] translate(input logic [3:0] rd,
                                                     input logic [4:0] mode);
    logic [PHY_IDX_W-1:0] idx;
    logic                 r13_14;
    idx    = {2'b00, rd};
    r13_14 = (rd == 4'd13) || (rd == 4'd14);
    unique case (mode)
      MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14)
                  idx = PHY_IDX_W'(PHY_FIQ_R8) + {2'b00, rd} - 6'd8;
      MODE_IRQ: if (r13_14) idx = PHY_IDX_W'(PHY_IRQ_R13) + {2'b00, rd} - 6'd13;
      MODE_SVC: if (r13_14) idx = PHY_IDX_W'(PHY_SVC_R13) + {2'b00, rd} - 6'd13;
      MODE_ABT: if (r13_14) idx = PHY_IDX_W'(PHY_ABT_R13) + {2'b00, rd} - 6'd13;
      MODE_UND: if (r13_14) idx = PHY_IDX_W'(PHY_UND_R13) + {2'b00, rd} - 6'd13;
      default:  idx = {2'b00, rd};
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zap_cp15_responder.sv
`default_nettype none
// ============================================================================
// Module  : zap_cp15_responder
// Purpose : CP15 side of the low-bandwidth coprocessor handshake. Executes
//           MRC/MCR through a private CPU register-file port and holds the
//           system-control registers used by the MMU and caches.
// Ports   : i_clk/i_reset          clock, async active-high reset
//           i_copro_dav/_word      request valid (held until done) + word
//           i_cpu_mode             CPSR mode (privilege + banking)
//           o_copro_done           completion flag
//           o_reg_en/_rd_index     register-file read request
//           i_reg_rd_data          read data, one cycle after o_reg_en
//           o_reg_wr_en/_index/_data  register-file write
//           i_fault_valid/i_fsr/i_far  abort capture
//           o_ctrl/o_ttb/o_dac/o_fsr/o_far  live CP15 register taps
// Rev     : 1.0  initial release
// ============================================================================
module zap_cp15_responder
  import zap_cp15_responder_pkg::*;
#(
  parameter int          PHY_REGS = 46,
  parameter int          CP_NUM   = 15,
  parameter logic [31:0] ID_VALUE = 32'h4100_0000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [4:0]                  i_cpu_mode,
  output logic                        o_copro_done,
  output logic                        o_reg_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_index,
  input  logic [31:0]                 i_reg_rd_data,
  output logic                        o_reg_wr_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_index,
  output logic [31:0]                 o_reg_wr_data,
  input  logic                        i_fault_valid,
  input  logic [31:0]                 i_fsr,
  input  logic [31:0]                 i_far,
  output logic [31:0]                 o_ctrl,
  output logic [31:0]                 o_ttb,
  output logic [31:0]                 o_dac,
  output logic [31:0]                 o_fsr,
  output logic [31:0]                 o_far
);

  localparam int IDX_W = $clog2(PHY_REGS);

  state_t             state_q, state_d;
  logic [3:0]         crn_q, crn_d;
  logic               done_q, done_d;
  logic               reg_en_q, reg_en_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [31:0]        ctrl_q, ctrl_d, ttb_q, ttb_d, dac_q, dac_d;
  logic [31:0]        fsr_q, fsr_d, far_q, far_d;

  // Decode of the incoming word (only consumed in IDLE, where it is latched).
  logic               req_l;
  logic [3:0]         req_crn;
  logic [3:0]         req_rd;
  logic               req_ignored;
  logic [IDX_W-1:0]   req_phy;
  logic [31:0]        req_rd_val;

  assign req_l       = i_copro_word[20];
  assign req_crn     = i_copro_word[19:16];
  assign req_rd      = i_copro_word[15:12];
  assign req_phy     = IDX_W'(translate(req_rd, i_cpu_mode));
  assign req_ignored = !is_mrc_mcr(i_copro_word)
                    || (i_copro_word[11:8] != 4'(CP_NUM))
                    || (i_cpu_mode == MODE_USR)
                    || (req_l && (req_rd == 4'd15));

  // Fields of the word that this block has no use for.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_copro_word[31:28], i_copro_word[23:21],
                       i_copro_word[7:5], i_copro_word[3:0]};

  always_comb begin
    req_rd_val = 32'h0;
    unique case (req_crn)
      CP15_ID:   req_rd_val = ID_VALUE;
      CP15_CTRL: req_rd_val = ctrl_q;
      CP15_TTB:  req_rd_val = ttb_q;
      CP15_DAC:  req_rd_val = dac_q;
      CP15_FSR:  req_rd_val = fsr_q;
      CP15_FAR:  req_rd_val = far_q;
      default:   req_rd_val = 32'h0;
    endcase
  end

  // FSM next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    crn_d     = crn_q;
    done_d    = 1'b0;
    reg_en_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_copro_dav) begin
          crn_d = req_crn;
          if (req_ignored) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (req_l) begin
            state_d   = S_WR;
            wr_en_d   = 1'b1;
            wr_idx_d  = req_phy;
            wr_data_d = req_rd_val;
          end else begin
            state_d  = S_RD_REQ;
            reg_en_d = 1'b1;
            rd_idx_d = req_phy;
          end
        end
      end
      S_RD_REQ: state_d = i_copro_dav ? S_RD_DATA : S_IDLE;
      S_RD_DATA, S_WR: begin
        // Dropping dav here aborts: no done, but the data move already
        // in flight this cycle is not cancelled.
        state_d = i_copro_dav ? S_DONE : S_IDLE;
        done_d  = i_copro_dav;
      end
      S_DONE: begin
        // Held here until dav falls so one request never fires twice.
        state_d = i_copro_dav ? S_DONE : S_IDLE;
        done_d  = i_copro_dav;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register bank next state; fault capture is applied last so it wins.
  always_comb begin
    ctrl_d = ctrl_q;
    ttb_d  = ttb_q;
    dac_d  = dac_q;
    fsr_d  = fsr_q;
    far_d  = far_q;
    if (state_q == S_RD_DATA) begin
      unique case (crn_q)
        CP15_CTRL: ctrl_d = i_reg_rd_data;
        CP15_TTB:  ttb_d  = i_reg_rd_data;
        CP15_DAC:  dac_d  = i_reg_rd_data;
        CP15_FSR:  fsr_d  = i_reg_rd_data;
        CP15_FAR:  far_d  = i_reg_rd_data;
        default:   ;
      endcase
    end
    if (i_fault_valid) begin
      fsr_d = i_fsr;
      far_d = i_far;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      crn_q     <= 4'd0;
      done_q    <= 1'b0;
      reg_en_q  <= 1'b0;
      rd_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 32'h0;
      ctrl_q    <= 32'h0;
      ttb_q     <= 32'h0;
      dac_q     <= 32'h0;
      fsr_q     <= 32'h0;
      far_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      crn_q     <= crn_d;
      done_q    <= done_d;
      reg_en_q  <= reg_en_d;
      rd_idx_q  <= rd_idx_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      ctrl_q    <= ctrl_d;
      ttb_q     <= ttb_d;
      dac_q     <= dac_d;
      fsr_q     <= fsr_d;
      far_q     <= far_d;
    end
  end

  assign o_copro_done   = done_q;
  assign o_reg_en       = reg_en_q;
  assign o_reg_rd_index = rd_idx_q;
  assign o_reg_wr_en    = wr_en_q;
  assign o_reg_wr_index = wr_idx_q;
  assign o_reg_wr_data  = wr_data_q;
  assign o_ctrl         = ctrl_q;
  assign o_ttb          = ttb_q;
  assign o_dac          = dac_q;
  assign o_fsr          = fsr_q;
  assign o_far          = far_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_cp15_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_zap_cp15_responder
// Purpose : Self-checking bench for zap_cp15_responder. Register-file
//           strobes are matched against a scoreboard filled when each
//           request is issued; CP15 taps are compared with a shadow model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_zap_cp15_responder;

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                         SVC = 5'b10011, ABT = 5'b10111, SYS = 5'b11111;
  localparam logic [31:0] ID = 32'h4100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dav = 1'b0;
  logic [31:0] word = 32'h0;
  logic [4:0]  mode = SVC;
  logic        done, reg_en, wr_en;
  logic [5:0]  rd_idx, wr_idx;
  logic [31:0] rd_data = 32'h0;
  logic [31:0] wr_data;
  logic        fault_v = 1'b0;
  logic [31:0] fsr_in = 32'h0, far_in = 32'h0;
  logic [31:0] ctrl, ttb, dac, fsr, far;

  zap_cp15_responder dut (
    .i_clk(clk), .i_reset(rst), .i_copro_dav(dav), .i_copro_word(word),
    .i_cpu_mode(mode), .o_copro_done(done), .o_reg_en(reg_en),
    .o_reg_rd_index(rd_idx), .i_reg_rd_data(rd_data), .o_reg_wr_en(wr_en),
    .o_reg_wr_index(wr_idx), .o_reg_wr_data(wr_data), .i_fault_valid(fault_v),
    .i_fsr(fsr_in), .i_far(far_in), .o_ctrl(ctrl), .o_ttb(ttb), .o_dac(dac),
    .o_fsr(fsr), .o_far(far)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] rf [0:45];
  logic [31:0] m_ctrl = 0, m_ttb = 0, m_dac = 0, m_fsr = 0, m_far = 0;
  logic [5:0]  rd_q [$];
  logic [37:0] wr_q [$];

  function automatic logic [5:0] m_phy(input logic [3:0] r, input logic [4:0] m);
    int i;
    i = int'(r);
    if (m == FIQ && i >= 8 && i <= 14) i = 16 + (i - 8);
    else if (i == 13 || i == 14) begin
      if (m == IRQ) i = 23 + (i - 13);
      if (m == SVC) i = 25 + (i - 13);
      if (m == ABT) i = 27 + (i - 13);
      if (m == 5'b11011) i = 29 + (i - 13);
    end
    return 6'(i);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] c);
    case (c)
      4'd0: return ID;
      4'd1: return m_ctrl;
      4'd2: return m_ttb;
      4'd3: return m_dac;
      4'd5: return m_fsr;
      4'd6: return m_far;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input bit l, input logic [3:0] crn,
                                     input logic [3:0] r, input logic [3:0] cp,
                                     input bit b4);
    return {4'hE, 4'hE, 3'b000, l, crn, r, cp, 3'b000, b4, 4'h0};
  endfunction

  // ---------------- register file + strobe monitor ----------------
  initial begin
    logic       pend = 1'b0;
    logic [5:0] pidx = 6'd0;
    forever begin
      @(negedge clk);
      rd_data = pend ? rf[pidx] : 32'hDEAD_BEEF;
      pend = reg_en;
      pidx = rd_idx;
      if (reg_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_idx), 32'hFFFF_FFFF);
        else chk("rd_idx", 32'(rd_idx), 32'(rd_q.pop_front()));
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_idx), 32'hFFFF_FFFF);
        else begin
          logic [37:0] e;
          e = wr_q.pop_front();
          chk("wr_idx", 32'(wr_idx), 32'(e[37:32]));
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  task automatic check_taps(input string tag);
    chk({tag, "_ctrl"}, ctrl, m_ctrl);
    chk({tag, "_ttb"},  ttb,  m_ttb);
    chk({tag, "_dac"},  dac,  m_dac);
    chk({tag, "_fsr"},  fsr,  m_fsr);
    chk({tag, "_far"},  far,  m_far);
  endtask

  // Issue one request; hold = cycles dav stays high after done appears,
  // fault_at / drop_at = cycle after the sampling edge for fault / dav drop.
  task automatic run_op(input string tag, input logic [31:0] w, input logic [4:0] m,
                        input int hold, input int fault_at, input int drop_at);
    bit   ign, l, dropped;
    int   lat, first;
    logic [3:0] crn, r;
    l   = w[20];
    crn = w[19:16];
    r   = w[15:12];
    ign = !(w[27:24] == 4'hE && w[4]) || (w[11:8] != 4'd15) || (m == USR)
          || (l && r == 4'd15);
    lat = ign ? 1 : (l ? 2 : 3);
    if (!ign && !l) rd_q.push_back(m_phy(r, m));
    if (!ign && l)  wr_q.push_back({m_phy(r, m), m_read(crn)});
    @(negedge clk);
    word = w; mode = m; dav = 1'b1;
    @(posedge clk);
    first = 0; dropped = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      fault_v = (n == fault_at);
      if (dropped) begin
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        break;
      end
      if (done && first == 0) first = n;
      else if (first != 0) chk({tag, "_done_hold"}, 32'(done), 32'd1);
      if (drop_at == n || (first != 0 && n >= first + hold)) begin
        dav = 1'b0;
        dropped = 1;
      end
    end
    fault_v = 1'b0;
    if (!dropped) chk({tag, "_timeout"}, 32'd0, 32'd1);
    if (drop_at == 0) chk({tag, "_latency"}, 32'(first), 32'(lat));
    else              chk({tag, "_no_done"}, 32'(first), 32'd0);
    if (!ign && !l && (drop_at == 0 || drop_at >= 2)) begin
      case (crn)
        4'd1: m_ctrl = rf[m_phy(r, m)];
        4'd2: m_ttb  = rf[m_phy(r, m)];
        4'd3: m_dac  = rf[m_phy(r, m)];
        4'd5: m_fsr  = rf[m_phy(r, m)];
        4'd6: m_far  = rf[m_phy(r, m)];
        default: ;
      endcase
    end
    if (fault_at > 0) begin
      m_fsr = fsr_in;
      m_far = far_in;
    end
    @(negedge clk);
    chk({tag, "_rd_q_empty"}, 32'(rd_q.size()), 32'd0);
    chk({tag, "_wr_q_empty"}, 32'(wr_q.size()), 32'd0);
    check_taps(tag);
  endtask

  initial begin
    for (int i = 0; i < 46; i++) rf[i] = 32'h1000_0000 + 32'(i * 32'h111);
    rf[1]  = 32'h8000_4000;
    rf[23] = 32'h0000_1005;
    rf[2]  = 32'hAAAA_5555;
    rf[27] = 32'h5555_0003;
    rf[4]  = 32'h0BAD_0BAD;

    repeat (3) @(negedge clk);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_reg_en", 32'(reg_en), 32'd0);
    chk("rst_wr_en",  32'(wr_en),  32'd0);
    chk("rst_wr_data", wr_data,    32'd0);
    check_taps("rst");
    rst = 1'b0;

    run_op("mcr_ttb",   mk(0, 4'd2, 4'd1,  4'd15, 1), SVC, 0, 0, 0);
    run_op("mrc_id",    mk(1, 4'd0, 4'd3,  4'd15, 1), SVC, 0, 0, 0);
    run_op("mrc_ttb",   mk(1, 4'd2, 4'd13, 4'd15, 1), SVC, 0, 0, 0);
    run_op("mcr_ctrl",  mk(0, 4'd1, 4'd13, 4'd15, 1), IRQ, 0, 0, 0);
    run_op("ign_usr",   mk(0, 4'd1, 4'd2,  4'd15, 1), USR, 0, 0, 0);
    run_op("ign_cp14",  mk(0, 4'd1, 4'd2,  4'd14, 1), SVC, 0, 0, 0);
    run_op("ign_cdp",   mk(0, 4'd1, 4'd2,  4'd15, 0), SVC, 0, 0, 0);
    run_op("ign_mrc15", mk(1, 4'd1, 4'd15, 4'd15, 1), SVC, 0, 0, 0);
    run_op("stall",     mk(1, 4'd1, 4'd14, 4'd15, 1), FIQ, 4, 0, 0);
    fsr_in = 32'h5; far_in = 32'h1234;
    run_op("fault_far", mk(0, 4'd6, 4'd2,  4'd15, 1), SVC, 0, 2, 0);
    run_op("mcr_c7",    mk(0, 4'd7, 4'd4,  4'd15, 1), SYS, 0, 0, 0);
    run_op("mrc_c7",    mk(1, 4'd7, 4'd4,  4'd15, 1), SYS, 0, 0, 0);
    run_op("abort_dac", mk(0, 4'd3, 4'd13, 4'd15, 1), ABT, 0, 0, 2);

    // Reset while the read request is outstanding.
    @(negedge clk);
    word = mk(0, 4'd1, 4'd1, 4'd15, 1); mode = SVC; dav = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_reg_en", 32'(reg_en), 32'd0);
    chk("arst_rd_idx", 32'(rd_idx), 32'd0);
    chk("arst_done",   32'(done),   32'd0);
    m_ctrl = 0; m_ttb = 0; m_dac = 0; m_fsr = 0; m_far = 0;
    check_taps("arst");
    dav = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst",  mk(0, 4'd3, 4'd13, 4'd15, 1), ABT, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
